// File: rtl/key_pkg.sv
// Shared constants for the keypad event unit: event kinds, the word tag,
// the field offsets inside an event word, and the word builder.
package key_pkg;

  localparam logic [7:0] KEY_TAG  = 8'h01;
  localparam int         TAG_LSB  = 24;
  localparam int         KIND_LSB = 16;
  localparam int         MAP_LSB  = 8;
  localparam int         IDX_LSB  = 0;

  typedef enum logic [1:0] {
    KIND_NONE    = 2'd0,
    KIND_PRESS   = 2'd1,
    KIND_RELEASE = 2'd2,
    KIND_REPEAT  = 2'd3
  } kind_e;

  function automatic logic [31:0] make_word(input kind_e kind, input logic [7:0] map,
                                            input logic [7:0] idx);
    logic [31:0] word;
    word                  = '0;
    word[TAG_LSB  +: 8]   = KEY_TAG;
    word[KIND_LSB +: 8]   = {6'd0, kind};
    word[MAP_LSB  +: 8]   = map;
    word[IDX_LSB  +: 8]   = idx;
    return word;
  endfunction

endpackage

// File: rtl/key_chan.sv
// One key: 2-FF synchroniser, tick-based debounce, auto-repeat timer and a
// single-entry pending register that always holds the most recent event kind.
module key_chan
  import key_pkg::*;
#(
  parameter int DEB_TICKS = 15,
  parameter int REP_DELAY = 64,
  parameter int REP_RATE  = 16
) (
  input  logic  i_clk,
  input  logic  i_rst,
  input  logic  i_tick,
  input  logic  i_key_n,
  input  logic  i_grant,
  output logic  o_pressed,
  output kind_e o_pend
);

  logic        r_sync1;
  logic        r_sync2;
  logic [7:0]  r_deb_cnt;
  logic        r_pressed;
  logic [15:0] r_rep_cnt;
  kind_e       r_pend;

  logic w_sync_pressed;
  logic w_differs;
  logic w_deb_done;
  logic w_rep_active;

  assign w_sync_pressed = ~r_sync2;
  assign w_differs      = (w_sync_pressed != r_pressed);
  assign w_deb_done     = w_differs && (r_deb_cnt == 8'(DEB_TICKS - 1));
  // A tick that changes the stable level never also counts toward a repeat.
  assign w_rep_active   = (REP_DELAY != 0) && r_pressed && !w_deb_done;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_deb_cnt <= '0;
      r_pressed <= 1'b0;
      r_rep_cnt <= '0;
      r_pend    <= KIND_NONE;
    end else begin
      r_sync1 <= i_key_n;
      r_sync2 <= r_sync1;
      if (i_grant) r_pend <= KIND_NONE;
      // Events are written after the grant clear so a same-cycle event is kept.
      if (i_tick) begin
        if (!w_differs) begin
          r_deb_cnt <= '0;
        end else if (w_deb_done) begin
          r_deb_cnt <= '0;
          r_pressed <= w_sync_pressed;
          if (w_sync_pressed) begin
            r_pend    <= KIND_PRESS;
            r_rep_cnt <= 16'(REP_DELAY);
          end else begin
            r_pend    <= KIND_RELEASE;
            r_rep_cnt <= '0;
          end
        end else begin
          r_deb_cnt <= r_deb_cnt + 8'd1;
        end
        if (w_rep_active) begin
          if (r_rep_cnt == 16'd1) begin
            r_pend    <= KIND_REPEAT;
            r_rep_cnt <= 16'(REP_RATE);
          end else if (r_rep_cnt != 16'd0) begin
            r_rep_cnt <= r_rep_cnt - 16'd1;
          end
        end
      end
    end
  end

  assign o_pressed = r_pressed;
  assign o_pend    = r_pend;

endmodule

// File: rtl/key_event_unit.sv
// Keypad event unit: per-key channels, lowest-index-first arbiter, event word
// formatter and a show-ahead event FIFO drained by the CPU.
module key_event_unit
  import key_pkg::*;
#(
  parameter int N_KEYS     = 5,
  parameter int DEB_TICKS  = 15,
  parameter int REP_DELAY  = 64,
  parameter int REP_RATE   = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_tick,
  input  logic [N_KEYS-1:0]            i_keys_n,
  input  logic                         i_pop,
  input  logic                         i_clr_ovf,
  output logic [31:0]                  o_out,
  output logic                         o_empty,
  output logic [$clog2(FIFO_DEPTH):0]  o_count,
  output logic                         o_overflow,
  output logic                         o_irq
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  kind_e             w_pend [N_KEYS];
  logic [N_KEYS-1:0] w_pressed;
  logic [N_KEYS-1:0] w_grant;
  logic              w_found;
  logic [7:0]        w_idx;
  kind_e             w_kind;

  for (genvar g = 0; g < N_KEYS; g++) begin : g_chan
    key_chan #(
      .DEB_TICKS (DEB_TICKS),
      .REP_DELAY (REP_DELAY),
      .REP_RATE  (REP_RATE)
    ) u_chan (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_tick    (i_tick),
      .i_key_n   (i_keys_n[g]),
      .i_grant   (w_grant[g]),
      .o_pressed (w_pressed[g]),
      .o_pend    (w_pend[g])
    );
  end

  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_idx   = '0;
    w_kind  = KIND_NONE;
    for (int i = 0; i < N_KEYS; i++) begin
      if (!w_found && (w_pend[i] != KIND_NONE)) begin
        w_found    = 1'b1;
        w_grant[i] = 1'b1;
        w_idx      = 8'(i);
        w_kind     = w_pend[i];
      end
    end
  end

  logic             r_push_vld;
  logic [31:0]      r_push_word;
  logic [31:0]      r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr;
  logic [PTR_W-1:0] r_rd;
  logic [CNT_W-1:0] r_count;
  logic [31:0]      r_out;
  logic             r_empty;
  logic             r_overflow;
  logic             r_irq;

  logic             w_full;
  logic             w_do_pop;
  logic             w_do_push;
  logic [PTR_W-1:0] w_head_idx;
  logic [CNT_W-1:0] w_next_count;
  logic [31:0]      w_next_out;

  assign w_full       = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_do_pop     = i_pop && (r_count != '0);
  assign w_do_push    = r_push_vld && (!w_full || w_do_pop);
  assign w_head_idx   = r_rd + PTR_W'(w_do_pop);
  assign w_next_count = r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);

  // The new head is the word being written when it lands in the head slot.
  always_comb begin
    w_next_out = '0;
    if (w_next_count != '0) begin
      if (w_do_push && (w_head_idx == r_wr)) w_next_out = r_push_word;
      else                                   w_next_out = r_mem[w_head_idx];
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst && w_do_push) r_mem[r_wr] <= r_push_word;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_push_vld  <= 1'b0;
      r_push_word <= '0;
      r_wr        <= '0;
      r_rd        <= '0;
      r_count     <= '0;
      r_out       <= '0;
      r_empty     <= 1'b1;
      r_overflow  <= 1'b0;
      r_irq       <= 1'b0;
    end else begin
      r_push_vld  <= w_found;
      r_push_word <= make_word(w_kind, 8'(w_pressed), w_idx);
      if (w_do_push) r_wr <= r_wr + PTR_W'(1);
      if (w_do_pop)  r_rd <= r_rd + PTR_W'(1);
      r_count <= w_next_count;
      r_out   <= w_next_out;
      r_empty <= (w_next_count == '0);
      r_irq   <= w_do_push;
      if (r_push_vld && !w_do_push) r_overflow <= 1'b1;
      else if (i_clr_ovf)           r_overflow <= 1'b0;
    end
  end

  assign o_out      = r_out;
  assign o_empty    = r_empty;
  assign o_count    = r_count;
  assign o_overflow = r_overflow;
  assign o_irq      = r_irq;

endmodule

// File: tb/tb_key_event_unit.sv
// Bench for key_event_unit: a tick-level event model plus directed scenarios
// with hand-computed event words.
module tb_key_event_unit;

  localparam int NK    = 5;
  localparam int DEB   = 3;
  localparam int RDLY  = 4;
  localparam int RRATE = 2;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_tick = 1'b0;
  logic [NK-1:0] i_keys_n = '1;
  logic          i_pop = 1'b0;
  logic          i_clr_ovf = 1'b0;
  logic [31:0]   o_out;
  logic          o_empty;
  logic [2:0]    o_count;
  logic          o_overflow;
  logic          o_irq;

  key_event_unit #(
    .N_KEYS     (NK),
    .DEB_TICKS  (DEB),
    .REP_DELAY  (RDLY),
    .REP_RATE   (RRATE),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .i_clk      (clk),
    .i_rst      (i_rst),
    .i_tick     (i_tick),
    .i_keys_n   (i_keys_n),
    .i_pop      (i_pop),
    .i_clr_ovf  (i_clr_ovf),
    .o_out      (o_out),
    .o_empty    (o_empty),
    .o_count    (o_count),
    .o_overflow (o_overflow),
    .o_irq      (o_irq)
  );

  always #5 clk = ~clk;

  int tickPhase = 0;
  always @(posedge clk) begin
    #1;
    tickPhase = (tickPhase + 1) % 4;
    i_tick = (tickPhase == 0);
  end

  int totalChecks = 0;
  int badChecks = 0;
  bit checkEn = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    totalChecks++;
    if (actual !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, actual, expected);
    end
  endtask

  // Model: keys seen through two clock delays, accepted once the last DEB tick
  // samples all disagree with the stable level; repeats follow from ticks held.
  logic [NK-1:0] mD1 = '1, mD2 = '1, mStable = '0;
  logic [NK-1:0] mSamples[$];
  int            mHeld[NK];
  int            mPend[NK];
  bit            mPushV = 1'b0;
  logic [31:0]   mPushW = '0;
  logic [31:0]   mQ[$];
  logic [31:0]   mPushLog[$];
  bit            mOvf = 1'b0, mIrq = 1'b0, mDoPop, mDoPush, mChg;
  int            tickCount = 0;
  int            cycleCount = 0;

  always @(posedge clk) begin
    cycleCount++;
    if (i_rst) begin
      mD1 = '1; mD2 = '1; mStable = '0;
      mSamples.delete();
      for (int i = 0; i < NK; i++) begin mHeld[i] = 0; mPend[i] = 0; end
      mPushV = 1'b0; mQ.delete(); mOvf = 1'b0; mIrq = 1'b0;
    end else begin
      mDoPop  = i_pop && (mQ.size() > 0);
      mDoPush = mPushV && ((mQ.size() < DEPTH) || mDoPop);
      if (mPushV && !mDoPush) mOvf = 1'b1;
      else if (i_clr_ovf)     mOvf = 1'b0;
      if (mDoPop) void'(mQ.pop_front());
      if (mDoPush) begin mQ.push_back(mPushW); mPushLog.push_back(mPushW); end
      mIrq = mDoPush;
      mPushV = 1'b0;
      for (int i = 0; i < NK; i++) begin
        if (!mPushV && mPend[i] != 0) begin
          mPushV = 1'b1;
          mPushW = {8'h01, 8'(mPend[i]), {3'b000, mStable}, 8'(i)};
          mPend[i] = 0;
        end
      end
      if (i_tick) begin
        tickCount++;
        mSamples.push_back(~mD2);
        if (mSamples.size() > DEB) void'(mSamples.pop_front());
        for (int i = 0; i < NK; i++) begin
          mChg = (mSamples.size() == DEB);
          for (int s = 0; s < mSamples.size(); s++)
            if (mSamples[s][i] == mStable[i]) mChg = 1'b0;
          if (mChg) begin
            mStable[i] = ~mStable[i];
            mPend[i] = mStable[i] ? 1 : 2;
            mHeld[i] = 0;
          end else if (mStable[i]) begin
            mHeld[i]++;
            if (mHeld[i] == RDLY || (mHeld[i] > RDLY && (mHeld[i] - RDLY) % RRATE == 0))
              mPend[i] = 3;
          end
        end
      end
      mD2 = mD1;
      mD1 = i_keys_n;
    end
  end

  logic [31:0] expOut;
  int          dutIrqCount = 0;
  int          irqCycles[$];
  logic [31:0] dutPopped[$];

  always @(negedge clk) begin
    if (checkEn) begin
      expOut = (mQ.size() > 0) ? mQ[0] : 32'h0;
      checkOutput("out", o_out, expOut);
      checkOutput("empty", 32'(o_empty), 32'(mQ.size() == 0));
      checkOutput("count", 32'(o_count), 32'(mQ.size()));
      checkOutput("overflow", 32'(o_overflow), 32'(mOvf));
      checkOutput("irq", 32'(o_irq), 32'(mIrq));
      if (o_irq === 1'b1) begin dutIrqCount++; irqCycles.push_back(cycleCount); end
      if (i_pop && o_empty === 1'b0) dutPopped.push_back(o_out);
    end
  end

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [NK-1:0] keysN, input logic pop, input logic clr);
    i_keys_n  = keysN;
    i_pop     = pop;
    i_clr_ovf = clr;
  endtask

  task automatic waitTicks(input int n);
    int target = tickCount + n;
    int guard = 0;
    while (tickCount < target && guard < 1000) begin stepCycle(); guard++; end
    if (tickCount < target) checkOutput("tickWait", 32'(tickCount), 32'(target));
  endtask

  task automatic drain();
    applyStimulus('1, 1'b1, 1'b0);
    waitTicks(8);
    applyStimulus('1, 1'b0, 1'b0);
    stepCycle();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int guard;
    i_rst = 1'b1;
    stepCycle();
    checkEn = 1'b1;
    stepCycle(); stepCycle();
    i_rst = 1'b0;
    checkOutput("rstOut", o_out, 32'h0);
    checkOutput("rstEmpty", 32'(o_empty), 32'd1);
    checkOutput("rstCount", 32'(o_count), 32'd0);
    checkOutput("rstOvf", 32'(o_overflow), 32'd0);
    checkOutput("rstIrq", 32'(o_irq), 32'd0);

    // Scenario 1: key2 held for 20 ticks with the CPU popping continuously.
    waitTicks(1);
    mPushLog.delete(); dutPopped.delete(); dutIrqCount = 0;
    applyStimulus(5'b11011, 1'b1, 1'b0);
    waitTicks(20);
    applyStimulus(5'b11111, 1'b1, 1'b0);
    waitTicks(6);
    applyStimulus('1, 1'b0, 1'b0);
    checkOutput("s1Words", 32'(dutPopped.size()), 32'd10);
    checkOutput("s1Irqs", 32'(dutIrqCount), 32'd10);
    checkOutput("s1ModelWords", 32'(mPushLog.size()), 32'd10);
    if (dutPopped.size() == 10) begin
      checkOutput("s1Press", dutPopped[0], 32'h0101_0402);
      checkOutput("s1Repeat", dutPopped[1], 32'h0103_0402);
      checkOutput("s1Release", dutPopped[9], 32'h0102_0002);
    end
    if (mPushLog.size() == 10) begin
      checkOutput("s1ModelPress", mPushLog[0], 32'h0101_0402);
      checkOutput("s1ModelRepeat", mPushLog[8], 32'h0103_0402);
      checkOutput("s1ModelRelease", mPushLog[9], 32'h0102_0002);
    end

    // Scenario 2: a two-tick glitch on key0 is filtered out.
    waitTicks(1);
    mPushLog.delete(); dutIrqCount = 0;
    applyStimulus(5'b11110, 1'b0, 1'b0);
    waitTicks(2);
    applyStimulus(5'b11111, 1'b0, 1'b0);
    waitTicks(5);
    checkOutput("s2Count", 32'(o_count), 32'd0);
    checkOutput("s2Irqs", 32'(dutIrqCount), 32'd0);
    checkOutput("s2ModelWords", 32'(mPushLog.size()), 32'd0);

    // Scenario 3: keys 0 and 3 on the same clock.
    waitTicks(1);
    mPushLog.delete(); irqCycles.delete();
    applyStimulus(5'b10110, 1'b0, 1'b0);
    waitTicks(4);
    checkOutput("s3Count", 32'(o_count), 32'd2);
    checkOutput("s3Head", o_out, 32'h0101_0900);
    checkOutput("s3IrqNum", 32'(irqCycles.size()), 32'd2);
    if (irqCycles.size() == 2)
      checkOutput("s3IrqGap", 32'(irqCycles[1] - irqCycles[0]), 32'd1);
    if (mPushLog.size() >= 2) checkOutput("s3ModelSecond", mPushLog[1], 32'h0101_0903);
    applyStimulus(5'b10110, 1'b1, 1'b0);
    stepCycle();
    applyStimulus(5'b10110, 1'b0, 1'b0);
    checkOutput("s3Second", o_out, 32'h0101_0903);
    drain();

    // Scenario 4: five presses into a four-entry FIFO.
    waitTicks(1);
    dutPopped.delete();
    applyStimulus(5'b00000, 1'b0, 1'b0);
    waitTicks(5);
    checkOutput("s4Count", 32'(o_count), 32'd4);
    checkOutput("s4Ovf", 32'(o_overflow), 32'd1);
    checkOutput("s4Head", o_out, 32'h0101_1F00);
    applyStimulus(5'b00000, 1'b0, 1'b1);
    stepCycle();
    checkOutput("s4OvfClr", 32'(o_overflow), 32'd0);
    applyStimulus(5'b11111, 1'b1, 1'b0);
    waitTicks(8);
    applyStimulus('1, 1'b0, 1'b0);
    if (dutPopped.size() >= 4) begin
      checkOutput("s4Word0", dutPopped[0], 32'h0101_1F00);
      checkOutput("s4Word1", dutPopped[1], 32'h0101_1F01);
      checkOutput("s4Word2", dutPopped[2], 32'h0101_1F02);
      checkOutput("s4Word3", dutPopped[3], 32'h0101_1F03);
    end else begin
      checkOutput("s4Popped", 32'(dutPopped.size()), 32'd4);
    end

    // Scenario 5: full FIFO with push and pop on the same edge.
    waitTicks(1);
    applyStimulus(5'b10000, 1'b0, 1'b0);
    waitTicks(1);
    applyStimulus(5'b00000, 1'b0, 1'b0);
    guard = 0;
    while (!(mPushV && mQ.size() == DEPTH) && guard < 200) begin stepCycle(); guard++; end
    checkOutput("s5Reached", 32'(guard < 200), 32'd1);
    applyStimulus(5'b00000, 1'b1, 1'b0);
    stepCycle();
    applyStimulus(5'b00000, 1'b0, 1'b0);
    checkOutput("s5Count", 32'(o_count), 32'd4);
    checkOutput("s5Ovf", 32'(o_overflow), 32'd0);
    checkOutput("s5Head", o_out, 32'h0101_0F01);
    drain();

    // Scenario 6: reset with queued entries and key1 mid-debounce.
    waitTicks(1);
    applyStimulus(5'b01010, 1'b0, 1'b0);
    waitTicks(5);
    applyStimulus(5'b01000, 1'b0, 1'b0);
    waitTicks(1);
    checkOutput("s6Queued", 32'(o_count), 32'd3);
    applyStimulus('1, 1'b0, 1'b0);
    i_rst = 1'b1;
    stepCycle();
    i_rst = 1'b0;
    checkOutput("s6Out", o_out, 32'h0);
    checkOutput("s6Empty", 32'(o_empty), 32'd1);
    checkOutput("s6Irq", 32'(o_irq), 32'd0);
    dutIrqCount = 0;
    waitTicks(8);
    checkOutput("s6NoStale", 32'(dutIrqCount), 32'd0);
    checkOutput("s6Count", 32'(o_count), 32'd0);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
